// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp_if
//  Brief    : Bus bundle for the multi-port register file (reads, writes, PC).
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     rd_en;
    logic [NUM_RD*AW-1:0]     ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*AW-1:0]     wa;
    logic [NUM_WR*DATA_W-1:0] wd;
    logic [DATA_W-1:0]        rpc;
    logic                     pc_wr_valid;
    logic [DATA_W-1:0]        pc_wr_data;

    modport master (
        output rd_en, ra, we, wa, wd, rpc,
        input  rd, pc_wr_valid, pc_wr_data
    );

    modport slave (
        input  rd_en, ra, we, wa, wd, rpc,
        output rd, pc_wr_valid, pc_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp
//  Brief    : Multi-port register file with write-to-read bypass; writes to
//             the PC index become a one-cycle redirect pulse to fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    reg_file_mp_if.slave    bus
);
    localparam int            AW       = $clog2(NUM_REGS);
    localparam int            NUM_ST   = NUM_REGS - 1;
    localparam logic [AW-1:0] c_pc_idx = AW'(NUM_REGS - 1);

    logic [NUM_ST-1:0][DATA_W-1:0] r_mem;
    logic [NUM_RD-1:0][DATA_W-1:0] r_rd;
    logic                          r_pc_valid;
    logic [DATA_W-1:0]             r_pc_data;

    logic [NUM_ST-1:0]             w_wr_hit;
    logic [NUM_ST-1:0][DATA_W-1:0] w_wr_data;
    logic                          w_pc_hit;
    logic [DATA_W-1:0]             w_pc_data;
    logic [NUM_RD-1:0][DATA_W-1:0] w_rd_next;

    // Ports are scanned in ascending order so the highest-numbered one wins.
    // Addresses beyond the PC index match nothing and are dropped.
    always_comb begin
        w_wr_hit  = '0;
        w_wr_data = '0;
        w_pc_hit  = 1'b0;
        w_pc_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.we[j]) begin
                for (int a = 0; a < NUM_ST; a++) begin
                    if (bus.wa[j*AW +: AW] == AW'(a)) begin
                        w_wr_hit[a]  = 1'b1;
                        w_wr_data[a] = bus.wd[j*DATA_W +: DATA_W];
                    end
                end
                if (bus.wa[j*AW +: AW] == c_pc_idx) begin
                    w_pc_hit  = 1'b1;
                    w_pc_data = bus.wd[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // PC reads always return rpc, never a same-cycle PC write.
    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.ra[i*AW +: AW] == c_pc_idx) begin
                w_rd_next[i] = bus.rpc;
            end else begin
                for (int a = 0; a < NUM_ST; a++) begin
                    if (bus.ra[i*AW +: AW] == AW'(a)) begin
                        w_rd_next[i] = w_wr_hit[a] ? w_wr_data[a] : r_mem[a];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem      <= '0;
            r_rd       <= '0;
            r_pc_valid <= 1'b0;
            r_pc_data  <= '0;
        end else begin
            for (int a = 0; a < NUM_ST; a++) begin
                if (w_wr_hit[a]) begin
                    r_mem[a] <= w_wr_data[a];
                end
            end
            if (bus.rd_en) begin
                r_rd <= w_rd_next;
            end
            r_pc_valid <= w_pc_hit;
            if (w_pc_hit) begin
                r_pc_data <= w_pc_data;
            end
        end
    end

    assign bus.rd          = r_rd;
    assign bus.pc_wr_valid = r_pc_valid;
    assign bus.pc_wr_data  = r_pc_data;
endmodule
`default_nettype wire
